instruction_fetch_stage: RTL and testbench

IF stage of the 5-stage MIPS pipeline; it is the requester side of the combinational instruction ROM.
- Owns the PC and drives the word address to instruction memory; the ROM decodes Address[9:2] and answers in the same cycle.
- Latches the returned instruction and PC+4 into the IF/ID pipeline register.
- Applies stall, jump redirect (resolved in ID) and branch redirect (resolved in EX), inserting NOP bubbles on redirect.
- Keeps a fetch counter for bench and debug.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_next_select.sv | 47 ++++
 rtl/instruction_fetch_stage.sv | 77 +++++++
 tb/tb_instruction_fetch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch defaults, PC step and the IF/ID bundle.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;

   // IF/ID pipeline register contents, also consumed by the decode stage.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   // Redirect targets are word addresses; low bits are silently dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_select.sv
// Next-PC priority selection for the fetch stage: branch > stall > jump > sequential.
module pc_next_select
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        if_id_load,
   output logic        bubble
);

   // Control semantics: these are level requests sampled on every rising edge,
   // with no ready/ack. A branch from EX always wins because anything younger
   // (including an ID jump) is on the wrong path. A stall freezes PC and IF/ID
   // and masks a jump; ID re-presents the jump once the stall clears.
   // A redirect writes a bubble into IF/ID; only the sequential case loads a
   // real instruction.

   // 32-bit add, wraps modulo 2^32 by construction.
   assign pc_plus4 = pc + PC_INCR;

   // Priority mux producing the next PC and the IF/ID update controls.
   always_comb begin
      next_pc    = pc_plus4;
      if_id_load = 1'b1;
      bubble     = 1'b0;
      if (branch_valid) begin
         next_pc    = word_align(branch_target);
         if_id_load = 1'b0;
         bubble     = 1'b1;
      end else if (stall) begin
         next_pc    = pc;
         if_id_load = 1'b0;
         bubble     = 1'b0;
      end else if (jump_valid) begin
         next_pc    = word_align(jump_target);
         if_id_load = 1'b0;
         bubble     = 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the combinational instruction ROM and
// registers the fetched word plus PC+4 into IF/ID.
module instruction_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        if_id_load;
   logic        bubble;
   if_id_t      if_id;

   pc_next_select u_pc_next_select (
      .pc            (pc),
      .stall         (stall),
      .jump_valid    (jump_valid),
      .jump_target   (jump_target),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .pc_plus4      (pc_plus4),
      .next_pc       (next_pc),
      .if_id_load    (if_id_load),
      .bubble        (bubble)
   );

   // PC register; imem_addr is taken straight from it so no input reaches the ROM address combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc <= RESET_PC;
      else       pc <= next_pc;
   end

   // IF/ID register: real fetch on sequential advance, bubble on redirect, hold on stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_id.instr    <= NOP_WORD;
         if_id.pc_plus4 <= 32'h0;
         if_id.valid    <= 1'b0;
      end else if (bubble) begin
         if_id.instr <= NOP_WORD;
         if_id.valid <= 1'b0;
      end else if (if_id_load) begin
         if_id.instr    <= imem_instr;
         if_id.pc_plus4 <= pc_plus4;
         if_id.valid    <= 1'b1;
      end
   end

   // Fetch counter: counts only real instructions latched into IF/ID.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           fetch_count <= 32'h0;
      else if (if_id_load) fetch_count <= fetch_count + 32'd1;
   end

   assign imem_addr      = pc;
   assign if_id_instr    = if_id.instr;
   assign if_id_pc_plus4 = if_id.pc_plus4;
   assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized
// control traffic against a fetch-rule reference model and a ROM model.
module tb_instruction_fetch_stage;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   // ROM model: 256 words decoded from address bits [9:2], higher bits alias.
   logic [31:0] rom [256];
   assign imem_instr = rom[imem_addr[9:2]];

   // Reference model state.
   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid;
   logic [31:0] exp_q[$];

   instruction_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .jump_valid     (jump_valid),
      .jump_target    (jump_target),
      .branch_valid   (branch_valid),
      .branch_target  (branch_target),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .fetch_count    (fetch_count)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
      exp_q.delete();
   endtask

   // Compare every DUT output against the model.
   task automatic compare_all(input string tag);
      check32({tag, ":imem_addr"}, imem_addr, m_pc);
      check32({tag, ":instr"}, if_id_instr, m_instr);
      check32({tag, ":pc_plus4"}, if_id_pc_plus4, m_pc4);
      check32({tag, ":valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
      check32({tag, ":fetch_count"}, fetch_count, m_count);
   endtask

   // Driver + model: apply one cycle of controls, advance model by the fetch rules, check.
   task automatic step(input string tag, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic s);
      logic [31:0] word;
      logic        loaded;
      branch_valid = b; branch_target = bt;
      jump_valid = j; jump_target = jt; stall = s;
      word   = rom[m_pc[9:2]];
      loaded = 1'b0;
      if (b) begin
         m_pc = bt & 32'hFFFF_FFFC; m_instr = 32'h0; m_valid = 1'b0;
      end else if (s) begin
         // hold everything
      end else if (j) begin
         m_pc = jt & 32'hFFFF_FFFC; m_instr = 32'h0; m_valid = 1'b0;
      end else begin
         m_instr = word; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
         m_valid = 1'b1; m_count = m_count + 32'd1;
         exp_q.push_back(word);
         loaded = 1'b1;
      end
      @(posedge clk);
      #1;
      compare_all(tag);
      if (loaded && exp_q.size() > 0) check32({tag, ":fetch_stream"}, if_id_instr, exp_q.pop_front());
      branch_valid = 1'b0; jump_valid = 1'b0; stall = 1'b0;
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom();
      rom[0]  = 32'h2004_0000;
      rom[11] = 32'h0c00_000c;
      rom[20] = 32'h0;
      reset = 1'b1; stall = 1'b0; jump_valid = 1'b0; branch_valid = 1'b0;
      jump_target = 32'h0; branch_target = 32'h0;
      model_reset();

      // 1. Reset state and first fetch.
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset = 1'b0;
      idle("first_fetch");
      check32("first_instr", if_id_instr, 32'h2004_0000);
      check32("first_pc4", if_id_pc_plus4, 32'h4);
      check32("first_addr", imem_addr, 32'h4);
      check32("first_count", fetch_count, 32'h1);

      // 2. Run to PC=0x10, stall two cycles, then resume.
      while (m_pc != 32'h10) idle("run_to_10");
      step("stall1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step("stall2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("stall_addr", imem_addr, 32'h10);
      check32("stall_instr", if_id_instr, rom[3]);
      idle("stall_release");
      check32("resume_instr", if_id_instr, rom[4]);
      check32("resume_pc4", if_id_pc_plus4, 32'h14);

      // 3. jal at 0x2C, ID redirects to 0x30.
      while (m_pc != 32'h30) idle("run_to_jal");
      check32("jal_latched", if_id_instr, 32'h0c00_000c);
      step("jump", 1'b0, 32'h0, 1'b1, 32'h30, 1'b0);
      check32("jump_addr", imem_addr, 32'h30);
      check32("jump_bubble", {31'h0, if_id_valid}, 32'h0);
      idle("after_jump");
      check32("after_jump_instr", if_id_instr, rom[12]);
      check32("after_jump_pc4", if_id_pc_plus4, 32'h34);

      // 4. Branch overrides jump and stall together.
      step("br_over_all", 1'b1, 32'h40, 1'b1, 32'h60, 1'b1);
      check32("br_addr", imem_addr, 32'h40);

      // Stall masks a jump.
      step("stall_masks_jump", 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);

      // 5. PC wrap at top of address space (misaligned target masked).
      step("br_top", 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
      check32("top_addr", imem_addr, 32'hFFFF_FFFC);
      idle("wrap");
      check32("wrap_addr", imem_addr, 32'h0);
      check32("wrap_pc4", if_id_pc_plus4, 32'h0);
      check32("wrap_instr", if_id_instr, rom[255]);

      // Randomized control traffic.
      for (int i = 0; i < 300; i++) begin
         logic b, j, s;
         logic [31:0] bt, jt;
         b  = ($urandom_range(0, 9) == 0);
         j  = ($urandom_range(0, 6) == 0);
         s  = ($urandom_range(0, 4) == 0);
         bt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
         jt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
         step("random", b, bt, j, jt, s);
      end

      // 6. Asynchronous reset between edges, with pending requests discarded.
      #3;
      stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h80;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("async_reset");
      @(posedge clk);
      #1;
      compare_all("reset_held");
      stall = 1'b0; branch_valid = 1'b0;
      reset = 1'b0;
      idle("post_reset_fetch");
      check32("post_reset_instr", if_id_instr, 32'h2004_0000);
      step("br_misaligned", 1'b1, 32'h43, 1'b0, 32'h0, 1'b0);
      check32("br_masked_addr", imem_addr, 32'h40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
